i2s_rx_deserializer: RTL and testbench
======================================

Name: i2s_rx_deserializer

Overview:
I2S receive stage that sits directly downstream of apb_i2s and consumes its i2s_master serial stream (SCK, WS, SD). It oversamples the three lines in the system clock domain and deserializes Philips-format words. It pairs each left word with the following right word and presents the pair on a valid/ready output register. It is used for loopback checking of apb_i2s and as the front end of a future receive path.

Parameters:
DATA_W, 16, bits per channel word; frame = 2*DATA_W SCK cycles
SYNC_STAGES, 2, synchronizer depth applied identically to i_sck, i_ws, i_sd (min 2)

Ports:
i_clk  in  1  system clock; only clock in the block
i_rst_n  in  1  reset, synchronous, active-low
i_en  in  1  receive enable; low clears alignment and shift state
i_sck  in  1  I2S bit clock from apb_i2s, asynchronous to i_clk
i_ws  in  1  word select: 0 = left, 1 = right
i_sd  in  1  serial data, MSB first
o_left  out  DATA_W  left sample of the current pair
o_right  out  DATA_W  right sample of the current pair
o_valid  out  1  pair held in output register
i_ready  in  1  consumer accepts the pair when o_valid && i_ready
o_overrun  out  1  one-cycle pulse when a completed pair is dropped
o_frame_err  out  1  one-cycle pulse when a word has the wrong bit count

Behaviour:
- Reset (i_rst_n=0 at posedge i_clk): every output is 0. All synchronizers, shift register, bit counter, aligned flag, left hold and ws_prev are cleared. Reset applied mid-word discards the partial word; no error pulse.
- Input timing: i_sck high and low phases must each be >=2 i_clk cycles. i_sck, i_ws and i_sd pass through equal-depth synchronizers, so they stay mutually aligned.
- SCK rising edge (rise) is detected on the synchronized SCK, from the last stage versus a delay flop. All processing below happens only in cycles where rise=1 and i_en=1.
- At each rise: sample ws_s and sd_s. The bit belongs to channel ws_prev (the WS value at the previous rise), which gives the Philips one-SCK delay.
  - Shift sd_s into shift_reg, MSB first.
  - Increment bit count, saturating at DATA_W+1.
- Word end: a rise where ws_s != ws_prev. The bit sampled at that rise is the LSB of the ws_prev word. Then set ws_prev <= ws_s and reset the count to 0.
  - If aligned=0: discard the word, set aligned=1, no error. The first partial word after reset or enable is always dropped.
  - If aligned=1 and count != DATA_W: pulse o_frame_err for 1 cycle, discard the word, and invalidate the left hold.
  - If aligned=1, count == DATA_W and channel is left: store the word in left hold and mark it valid.
  - If aligned=1, count == DATA_W, channel is right and left hold is valid: a pair is complete. Clear left hold valid.
  - If aligned=1, count == DATA_W, channel is right and left hold is invalid: discard the word silently.
- Output register, evaluated in the same cycle as pair completion:
  - If !o_valid, or o_valid && i_ready: load o_left/o_right and set o_valid=1 on the next edge. Latency is 1 i_clk after the completing rise cycle.
  - If o_valid && !i_ready: the new pair is dropped, the old pair is held unchanged, and o_overrun pulses for 1 cycle.
  - If o_valid && i_ready with no new pair: o_valid <= 0; o_left/o_right retain their values.
- i_en=0: aligned, count, shift_reg and left hold are cleared. ws_prev tracks ws_s, so re-enabling mid-frame does not create a false word end. The output register and handshake keep working.
- WS toggling with no rise in between cannot be observed and needs no special handling.

Test Plan:
- Align and pair: DATA_W=16, SCK period 8 i_clk, i_ready=1. Send L=0xA5C3, R=0x1234 twice after reset -> first partial word dropped; exactly one o_valid pulse with o_left=0xA5C3, o_right=0x1234 (assuming the stream starts mid-word). Complete pairs thereafter, 1 i_clk after the R LSB rise.
- Backpressure: hold i_ready=0 across two pairs (0x1111/0x2222 then 0x3333/0x4444) -> output holds 0x1111/0x2222; o_overrun pulses once at the second pair. Then assert i_ready -> o_valid drops the next cycle.
- Frame error: send a 15-bit left word, then valid R=0x00FF -> o_frame_err pulses at the L end; the R word is discarded; no o_valid. The next full pair 0xBEEF/0xCAFE is delivered correctly.
- Reset mid-word: pulse i_rst_n low for 2 cycles halfway through L -> all outputs 0. The next partial word is dropped (realigning), then the next full pair is received correctly.
- Enable gating: i_en=0 for one frame, then high mid-frame -> no output and no error during the disabled frame; the first pair after re-enable is the first complete L/R pair.
- Loopback: connect to apb_i2s i2s_master and write TXL=0x0000ABCD, TXR=0x00001234 -> received pair equals the written values truncated to DATA_W.

Source files
------------

// File: rtl/i2s_rx_deserializer_if.sv
// Pair output bus of the I2S receiver: left/right sample pair with a valid/ready handshake.
interface i2s_rx_deserializer_if #(
    parameter int DATA_W = 16
) ();
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
    logic              valid;
    logic              ready;

    modport master (output left, output right, output valid, input ready);
    modport slave  (input left, input right, input valid, output ready);
endinterface

// File: rtl/i2s_rx_deserializer.sv
// Philips I2S receiver: oversamples SCK/WS/SD in the system clock domain, deserializes
// words, pairs left with the following right and presents the pair on a valid/ready register.
module i2s_rx_deserializer #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_en,
    input  logic                         i_sck,
    input  logic                         i_ws,
    input  logic                         i_sd,
    i2s_rx_deserializer_if.master        o_pair,
    output logic                         o_overrun,
    output logic                         o_frame_err
);
    localparam int CNT_W = $clog2(DATA_W + 2);

    typedef enum logic {ST_HUNT, ST_ALIGNED} state_t;

    logic [SYNC_STAGES-1:0] r_sck_sync, r_ws_sync, r_sd_sync;
    logic                   r_sck_d;
    logic [DATA_W-1:0]      r_shift, r_lhold, r_left, r_right;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ws_prev, r_lhold_vld, r_valid, r_overrun, r_ferr;
    state_t                 r_state, w_state_nxt;

    logic                   w_sck_s, w_ws_s, w_sd_s, w_rise, w_step, w_word_end;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic [DATA_W-1:0]      w_shift_nxt;
    logic                   w_ferr, w_lhold_ld, w_lhold_clr, w_pair_done;

    // Equal-depth chains keep SCK, WS and SD mutually aligned after synchronization.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sck_sync <= '0;
            r_ws_sync  <= '0;
            r_sd_sync  <= '0;
            r_sck_d    <= 1'b0;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
            r_ws_sync  <= {r_ws_sync[SYNC_STAGES-2:0], i_ws};
            r_sd_sync  <= {r_sd_sync[SYNC_STAGES-2:0], i_sd};
            r_sck_d    <= w_sck_s;
        end
    end

    assign w_sck_s     = r_sck_sync[SYNC_STAGES-1];
    assign w_ws_s      = r_ws_sync[SYNC_STAGES-1];
    assign w_sd_s      = r_sd_sync[SYNC_STAGES-1];
    assign w_rise      = w_sck_s & ~r_sck_d;
    assign w_step      = w_rise & i_en;
    assign w_word_end  = w_step && (w_ws_s != r_ws_prev);
    assign w_cnt_inc   = (r_cnt == CNT_W'(DATA_W + 1)) ? r_cnt : r_cnt + 1'b1;
    assign w_shift_nxt = {r_shift[DATA_W-2:0], w_sd_s};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= ST_HUNT;
        else          r_state <= w_state_nxt;
    end

    // Word-end classification; r_ws_prev is the channel the finished word belongs to.
    always_comb begin
        w_state_nxt = r_state;
        w_ferr      = 1'b0;
        w_lhold_ld  = 1'b0;
        w_lhold_clr = 1'b0;
        w_pair_done = 1'b0;
        if (!i_en) begin
            w_state_nxt = ST_HUNT;
            w_lhold_clr = 1'b1;
        end else if (w_word_end) begin
            case (r_state)
                ST_HUNT: w_state_nxt = ST_ALIGNED;
                ST_ALIGNED: begin
                    if (w_cnt_inc != CNT_W'(DATA_W)) begin
                        w_ferr      = 1'b1;
                        w_lhold_clr = 1'b1;
                    end else if (!r_ws_prev) begin
                        w_lhold_ld  = 1'b1;
                    end else if (r_lhold_vld) begin
                        w_pair_done = 1'b1;
                        w_lhold_clr = 1'b1;
                    end
                end
                default: w_state_nxt = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_ws_prev   <= 1'b0;
            r_lhold     <= '0;
            r_lhold_vld <= 1'b0;
        end else begin
            if (!i_en) begin
                r_shift   <= '0;
                r_cnt     <= '0;
                r_ws_prev <= w_ws_s;
            end else if (w_step) begin
                r_shift <= w_shift_nxt;
                if (w_word_end) begin
                    r_cnt     <= '0;
                    r_ws_prev <= w_ws_s;
                end else begin
                    r_cnt     <= w_cnt_inc;
                end
            end
            if (!i_en) begin
                r_lhold     <= '0;
                r_lhold_vld <= 1'b0;
            end else if (w_lhold_ld) begin
                r_lhold     <= w_shift_nxt;
                r_lhold_vld <= 1'b1;
            end else if (w_lhold_clr) begin
                r_lhold_vld <= 1'b0;
            end
        end
    end

    // A new pair replaces the held one only if the consumer took it or none is held.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_left    <= '0;
            r_right   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            r_ferr    <= w_ferr;
            if (w_pair_done) begin
                if (!r_valid || o_pair.ready) begin
                    r_left  <= r_lhold;
                    r_right <= w_shift_nxt;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && o_pair.ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_pair.left  = r_left;
    assign o_pair.right = r_right;
    assign o_pair.valid = r_valid;
    assign o_overrun    = r_overrun;
    assign o_frame_err  = r_ferr;
endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench for i2s_rx_deserializer: drives a Philips I2S stream (SCK = 8 i_clk) and
// checks pairing, backpressure, frame errors, mid-word reset and enable gating.
module tb_i2s_rx_deserializer;
    localparam int DATA_W = 16;

    logic i_clk = 1'b0;
    logic i_rst_n, i_en, i_sck, i_ws, i_sd;
    logic o_overrun, o_frame_err;

    i2s_rx_deserializer_if #(.DATA_W(DATA_W)) pair_if ();

    i2s_rx_deserializer #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (i_en),
        .i_sck       (i_sck),
        .i_ws        (i_ws),
        .i_sd        (i_sd),
        .o_pair      (pair_if.master),
        .o_overrun   (o_overrun),
        .o_frame_err (o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_ovr = 0;
    int n_ferr = 0;
    logic [DATA_W-1:0] acc_l = '0;
    logic [DATA_W-1:0] acc_r = '0;

    // Observes accepted pairs and event pulses away from the active edge.
    always @(negedge i_clk) begin
        if (pair_if.valid && pair_if.ready) begin
            n_acc++;
            acc_l = pair_if.left;
            acc_r = pair_if.right;
        end
        if (o_overrun)   n_ovr++;
        if (o_frame_err) n_ferr++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_bit(input logic ws, input logic sd);
        i_sck = 1'b0;
        i_ws  = ws;
        i_sd  = sd;
        repeat (4) tick();
        i_sck = 1'b1;
        repeat (4) tick();
    endtask

    // Sends bits hi..lo of a word; WS flips during bit 0 (Philips one-SCK lead).
    task automatic send_seg(input logic ch, input logic [DATA_W-1:0] data, input int hi, input int lo);
        for (int i = hi; i >= lo; i--)
            send_bit((i == 0) ? ~ch : ch, data[i]);
    endtask

    task automatic send_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        send_seg(1'b0, l, DATA_W-1, 0);
        send_seg(1'b1, r, DATA_W-1, 0);
        repeat (8) tick();
    endtask

    initial begin
        int acc0;
        i_rst_n = 1'b0;
        i_en    = 1'b1;
        i_sck   = 1'b0;
        i_ws    = 1'b0;
        i_sd    = 1'b0;
        pair_if.ready = 1'b1;
        repeat (4) tick();
        chk("rst_valid", {31'd0, pair_if.valid}, 32'd0);
        chk("rst_left",  {16'd0, pair_if.left},  32'd0);
        chk("rst_right", {16'd0, pair_if.right}, 32'd0);
        chk("rst_ovr",   {31'd0, o_overrun},     32'd0);
        chk("rst_ferr",  {31'd0, o_frame_err},   32'd0);
        i_rst_n = 1'b1;
        repeat (2) tick();

        // Start mid-left: partial L aligns, lone R dropped, then one real pair.
        send_seg(1'b0, 16'hA5C3, 7, 0);
        send_seg(1'b1, 16'h1234, DATA_W-1, 0);
        send_pair(16'hA5C3, 16'h1234);
        chk("align_cnt",   n_acc, 1);
        chk("align_left",  {16'd0, acc_l}, 32'h0000A5C3);
        chk("align_right", {16'd0, acc_r}, 32'h00001234);
        chk("align_vld_drop", {31'd0, pair_if.valid}, 32'd0);
        send_pair(16'h5A5A, 16'h0F0F);
        chk("pair2_cnt",   n_acc, 2);
        chk("pair2_left",  {16'd0, acc_l}, 32'h00005A5A);
        chk("pair2_right", {16'd0, acc_r}, 32'h00000F0F);
        chk("pair_noerr",  n_ferr + n_ovr, 0);

        // Backpressure across two pairs.
        pair_if.ready = 1'b0;
        send_pair(16'h1111, 16'h2222);
        send_pair(16'h3333, 16'h4444);
        chk("bp_valid", {31'd0, pair_if.valid}, 32'd1);
        chk("bp_left",  {16'd0, pair_if.left},  32'h00001111);
        chk("bp_right", {16'd0, pair_if.right}, 32'h00002222);
        chk("bp_ovr",   n_ovr, 1);
        chk("bp_cnt",   n_acc, 2);
        pair_if.ready = 1'b1;
        tick();
        chk("bp_vld_drop", {31'd0, pair_if.valid}, 32'd0);
        chk("bp_acc_cnt", n_acc, 3);
        chk("bp_acc_left", {16'd0, acc_l}, 32'h00001111);

        // 15-bit left word: error, following right discarded, next pair fine.
        send_seg(1'b0, 16'h7FFF, DATA_W-2, 0);
        send_seg(1'b1, 16'h00FF, DATA_W-1, 0);
        repeat (8) tick();
        chk("ferr_cnt",   n_ferr, 1);
        chk("ferr_nopair", n_acc, 3);
        send_pair(16'hBEEF, 16'hCAFE);
        chk("ferr_next_cnt",   n_acc, 4);
        chk("ferr_next_left",  {16'd0, acc_l}, 32'h0000BEEF);
        chk("ferr_next_right", {16'd0, acc_r}, 32'h0000CAFE);

        // Reset halfway through a left word.
        send_seg(1'b0, 16'hFFFF, DATA_W-1, 8);
        i_rst_n = 1'b0;
        repeat (2) tick();
        chk("mrst_valid", {31'd0, pair_if.valid}, 32'd0);
        chk("mrst_left",  {16'd0, pair_if.left},  32'd0);
        chk("mrst_right", {16'd0, pair_if.right}, 32'd0);
        i_rst_n = 1'b1;
        send_seg(1'b0, 16'hFFFF, 7, 0);
        send_seg(1'b1, 16'h7777, DATA_W-1, 0);
        send_pair(16'h1357, 16'h2468);
        chk("mrst_cnt",   n_acc, 5);
        chk("mrst_left2", {16'd0, acc_l}, 32'h00001357);
        chk("mrst_right2", {16'd0, acc_r}, 32'h00002468);
        chk("mrst_noerr", n_ferr, 1);

        // Disabled for a frame, re-enabled in the middle of the right word.
        i_en = 1'b0;
        acc0 = n_acc;
        send_seg(1'b0, 16'h9999, DATA_W-1, 0);
        send_seg(1'b1, 16'h8888, DATA_W-1, 8);
        chk("en_nopair", n_acc, acc0);
        chk("en_noerr",  n_ferr, 1);
        i_en = 1'b1;
        send_seg(1'b1, 16'h8888, 7, 0);
        send_pair(16'h0BAD, 16'hF00D);
        chk("en_cnt",   n_acc, acc0 + 1);
        chk("en_left",  {16'd0, acc_l}, 32'h00000BAD);
        chk("en_right", {16'd0, acc_r}, 32'h0000F00D);
        chk("en_noerr2", n_ferr, 1);
        chk("end_ovr",   n_ovr, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
